pads_config_seq: RTL and testbench

- Parametrised successor to the static pad-direction decoder: drives per-pad receive-enable (re) and output-enable (oe) for N_PADS user/mgmt pads.
- Adds a handshaked configuration update with break-before-make sequencing. A pad whose direction flips passes through a programmable dead time with both enables off, so a pad is never driven while its receiver path is also switching.
- Sits between the configuration register block and the pad ring.

---
 rtl/pads_config_seq.sv | 123 ++++++++++++
 tb/tb_pads_config_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pads_config_seq.sv
// Pad receive/output-enable sequencer with handshaked, break-before-make configuration updates.
// Optional macro PADS_CONFIG_LOCK_EN adds a sticky lock that freezes the LOCK_MASK pads.
module pads_config_seq #(
    parameter int unsigned        N_PADS    = 44,
    parameter int unsigned        DEAD_CYC  = 4,
    parameter logic [N_PADS-1:0]  RST_RE    = '1,
    parameter logic [N_PADS-1:0]  LOCK_MASK = '0
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic [N_PADS-1:0] cnfg_io,
    input  logic [N_PADS-1:0] cnfg_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_done,
    input  logic              lock_req,
    output logic              cfg_locked,
    output logic [N_PADS-1:0] re,
    output logic [N_PADS-1:0] oe
);

    typedef enum logic {IDLE, DEAD} state_t;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    logic [N_PADS-1:0] re_n, oe_n;
    logic [N_PADS-1:0] sh_re, sh_oe, sh_re_n, sh_oe_n;
    logic [N_PADS-1:0] flip, flip_n;
    logic [N_PADS-1:0] keep, tgt_re, tgt_oe, flip_now;
    logic              done_n;

`ifdef PADS_CONFIG_LOCK_EN
    logic locked;

    // The lock register is read before update, so an accept on the lock edge stays unlocked.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            locked <= 1'b0;
        end else if (lock_req && cfg_ready) begin
            locked <= 1'b1;
        end
    end

    assign cfg_locked = locked;
    assign keep       = locked ? LOCK_MASK : '0;
`else
    logic unused_lock;

    assign unused_lock = ^{lock_req, LOCK_MASK};
    assign cfg_locked  = 1'b0;
    assign keep        = '0;
`endif

    // Locked pads target their current pair, so they can never flip.
    assign tgt_re   = (keep & re) | (~keep & cnfg_en & ~cnfg_io);
    assign tgt_oe   = (keep & oe) | (~keep & cnfg_en & cnfg_io);
    assign flip_now = (re | oe) & (tgt_re | tgt_oe) & ((re ^ tgt_re) | (oe ^ tgt_oe));

    assign cfg_ready = (state == IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        re_n    = re;
        oe_n    = oe;
        sh_re_n = sh_re;
        sh_oe_n = sh_oe;
        flip_n  = flip;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (cfg_valid) begin
                    re_n    = tgt_re & ~flip_now;
                    oe_n    = tgt_oe & ~flip_now;
                    sh_re_n = tgt_re;
                    sh_oe_n = tgt_oe;
                    flip_n  = flip_now;
                    if (|flip_now) begin
                        state_n = DEAD;
                        cnt_n   = 8'(DEAD_CYC - 1);
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (cnt == 8'd0) begin
                    re_n    = (re & ~flip) | (sh_re & flip);
                    oe_n    = (oe & ~flip) | (sh_oe & flip);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= IDLE;
            cnt      <= '0;
            re       <= RST_RE;
            oe       <= '0;
            sh_re    <= '0;
            sh_oe    <= '0;
            flip     <= '0;
            cfg_done <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            re       <= re_n;
            oe       <= oe_n;
            sh_re    <= sh_re_n;
            sh_oe    <= sh_oe_n;
            flip     <= flip_n;
            cfg_done <= done_n;
        end
    end

endmodule

// File: tb/tb_pads_config_seq.sv
// Randomized bench for pads_config_seq against a per-pad behavioural model, plus directed literal checks.
module tb_pads_config_seq;

    localparam int unsigned N  = 44;
    localparam int unsigned DC = 4;
    localparam logic [N-1:0] LMASK = 44'h1;
`ifdef PADS_CONFIG_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetb = 1'b0;
    logic [N-1:0] cnfg_io = '0;
    logic [N-1:0] cnfg_en = '0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic         cfg_done;
    logic         lock_req = 1'b0;
    logic         cfg_locked;
    logic [N-1:0] re;
    logic [N-1:0] oe;

    pads_config_seq #(
        .N_PADS   (N),
        .DEAD_CYC (DC),
        .RST_RE   ('1),
        .LOCK_MASK(LMASK)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .cnfg_io   (cnfg_io),
        .cnfg_en   (cnfg_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .lock_req  (lock_req),
        .cfg_locked(cfg_locked),
        .re        (re),
        .oe        (oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: what each pad must show, plus a pending list of pads still in dead time.
    bit [N-1:0] m_re, m_oe, p_re, p_oe, p_mask;
    bit         m_ready, m_done, m_locked;
    int         dead_left;
    logic [N-1:0] prev_re, prev_oe;
    bit         have_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit v, input bit [N-1:0] io, input bit [N-1:0] en,
                         input bit lk, input bit rb);
        bit was_ready, was_locked, any, cr, co, tr, to;
        was_ready  = m_ready;
        was_locked = m_locked;
        if (!rb) begin
            m_re = '1; m_oe = '0; m_ready = 1'b1; m_done = 1'b0; m_locked = 1'b0;
            dead_left = 0; p_mask = '0;
            return;
        end
        m_done = 1'b0;
        if (was_ready && v) begin
            any = 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                cr = m_re[i]; co = m_oe[i];
                tr = en[i] & ~io[i];
                to = en[i] & io[i];
                if (LOCK_ON && was_locked && LMASK[i]) begin
                    tr = cr; to = co;
                end
                if ((cr | co) && (tr | to) && (cr != tr || co != to)) begin
                    m_re[i] = 1'b0; m_oe[i] = 1'b0;
                    p_mask[i] = 1'b1; p_re[i] = tr; p_oe[i] = to;
                    any = 1'b1;
                end else begin
                    m_re[i] = tr; m_oe[i] = to; p_mask[i] = 1'b0;
                end
            end
            if (any) begin
                m_ready = 1'b0;
                dead_left = DC;
            end else begin
                m_done = 1'b1;
            end
        end else if (!was_ready) begin
            dead_left--;
            if (dead_left == 0) begin
                for (int i = 0; i < int'(N); i++)
                    if (p_mask[i]) begin
                        m_re[i] = p_re[i]; m_oe[i] = p_oe[i];
                    end
                m_done  = 1'b1;
                m_ready = 1'b1;
            end
        end
        if (LOCK_ON && was_ready && lk) m_locked = 1'b1;
    endtask

    task automatic compare(input bit rb);
        chk("re", re, m_re);
        chk("oe", oe, m_oe);
        chk("cfg_ready", cfg_ready, m_ready);
        chk("cfg_done", cfg_done, m_done);
        chk("cfg_locked", cfg_locked, m_locked);
        chk("re_and_oe", re & oe, '0);
        // Reset may legitimately jump an output pad straight back to input.
        if (have_prev && rb) begin
            chk("oe_to_re", prev_oe & re, '0);
            chk("re_to_oe", prev_re & oe, '0);
        end
        prev_re = re; prev_oe = oe; have_prev = 1'b1;
    endtask

    task automatic step(input bit v, input bit [N-1:0] io, input bit [N-1:0] en,
                        input bit lk, input bit rb);
        cfg_valid = v; cnfg_io = io; cnfg_en = en; lock_req = lk; resetb = rb;
        @(posedge clk);
        model(v, io, en, lk, rb);
        #1;
        compare(rb);
    endtask

    initial begin
        bit [N-1:0] en, io;
        logic [63:0] r1, r2;

        // Reset held two cycles.
        step(0, '0, '0, 0, 0);
        step(0, '0, '0, 0, 0);
        chk("rst_re_lit", re, 44'hFFF_FFFF_FFFF);
        chk("rst_oe_lit", oe, 44'h0);
        chk("rst_ready_lit", cfg_ready, 1'b1);
        chk("rst_done_lit", cfg_done, 1'b0);

        // No-flip update: pad 5 disabled.
        en = '1; en[5] = 1'b0; io = '0;
        step(1, io, en, 0, 1);
        chk("noflip_re_lit", re, 44'hFFF_FFFF_FFDF);
        chk("noflip_done_lit", cfg_done, 1'b1);
        chk("noflip_ready_lit", cfg_ready, 1'b1);
        step(0, io, en, 0, 1);
        chk("noflip_done_clr_lit", cfg_done, 1'b0);

        // Pad 6 flips to output; valid held with junk data during the dead time.
        io[6] = 1'b1;
        step(1, io, en, 0, 1);
        chk("flip_dead_lit", {re[6], oe[6], cfg_ready}, 3'b000);
        for (int k = 0; k < 3; k++) begin
            step(1, '1, 44'h0F0F, 0, 1);
            chk("flip_hold_lit", {re[6], oe[6], cfg_ready, cfg_done}, 4'b0000);
        end
        step(1, '1, 44'h0F0F, 0, 1);
        chk("flip_oe_lit", oe, 44'h40);
        chk("flip_re_lit", re, 44'hFFF_FFFF_FF9F);
        chk("flip_done_lit", cfg_done, 1'b1);
        step(0, io, en, 0, 1);
        chk("flip_done_once_lit", cfg_done, 1'b0);

        // Reset on the second dead cycle.
        io[6] = 1'b0;
        step(1, io, en, 0, 1);
        step(0, io, en, 0, 1);
        step(0, io, en, 0, 0);
        chk("middead_re_lit", re, 44'hFFF_FFFF_FFFF);
        chk("middead_oe_lit", oe, 44'h0);
        chk("middead_done_lit", cfg_done, 1'b0);
        step(0, io, en, 0, 1);
        chk("middead_nodone_lit", cfg_done, 1'b0);

`ifdef PADS_CONFIG_LOCK_EN
        step(0, '0, '1, 1, 1);
        chk("lock_set_lit", cfg_locked, 1'b1);
        step(1, 44'h3, '1, 0, 1);
        chk("lock_re_lit", re, 44'hFFF_FFFF_FFFD);
        chk("lock_oe_lit", oe, 44'h0);
        for (int k = 0; k < int'(DC) - 1; k++) step(0, '0, '1, 0, 1);
        step(0, '0, '1, 0, 1);
        chk("lock_after_re_lit", re, 44'hFFF_FFFF_FFFD);
        chk("lock_after_oe_lit", oe, 44'h2);
`else
        step(0, '0, '1, 1, 1);
        chk("lock_ignored_lit", cfg_locked, 1'b0);
`endif

        // Randomized traffic with occasional lock requests and resets.
        step(0, '0, '0, 0, 0);
        io = '0; en = '1;
        for (int c = 0; c < 600; c++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) io = io ^ (r1[N-1:0] & r2[N-1:0]);
            if ($urandom_range(0, 5) == 0) en = en ^ (r1[N-1:0] & ~r2[N-1:0] & {N{1'b1}} & r2[N+3:4]);
            step($urandom_range(0, 2) != 0, io, en,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
